// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard sequencer: FSM state encoding and counter sizing.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } hz_state_e;

  // One counter serves both the MD watchdog and the flush countdown.
  function automatic int cnt_width(input int md_timeout, input int flush_cycles);
    int m;
    m = (md_timeout > flush_cycles) ? md_timeout : flush_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle. Stats outputs exist only with HAZARD_STATS_EN.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W   = 32
`endif
);
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_md_start, md_done;
  logic pc_stall, if_id_stall, if_id_flush, decode_stall, md_timeout;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_stall_cycles, stat_flush_events;
`endif

  modport master (
    output id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read,
           ex_redirect, ex_md_start, md_done,
    input  pc_stall, if_id_stall, if_id_flush, decode_stall, md_timeout
`ifdef HAZARD_STATS_EN
    , input stat_stall_cycles, stat_flush_events
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read,
           ex_redirect, ex_md_start, md_done,
    output pc_stall, if_id_stall, if_id_flush, decode_stall, md_timeout
`ifdef HAZARD_STATS_EN
    , output stat_stall_cycles, stat_flush_events
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  output logic [STAT_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)                q <= '0;
    else if (inc && !(&q))  q <= q + 1'b1;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, EX redirect, mul/div occupancy).
// Optional HAZARD_STATS_EN adds saturating stall-cycle and flush-event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int               CNT_W        = cnt_width(MD_TIMEOUT, FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] MD_LAST      = CNT_W'(MD_TIMEOUT - 1);

  hz_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic                  md_timeout_q;
  logic [REG_ADDR_W-1:0] rd;
  logic                  load_use, flush, hold;

  assign rd = hz.ex_rd;

  always_comb begin
    load_use = hz.ex_mem_read && (rd != '0) &&
               ((hz.id_use_rs1 && (hz.id_rs1 == rd)) ||
                (hz.id_use_rs2 && (hz.id_rs2 == rd)));
    flush    = hz.ex_redirect || (state == ST_FLUSH);
    // Flush outranks any hold so IF/ID is never both held and cleared.
    hold     = !flush &&
               (((state == ST_RUN) && !hz.ex_md_start && load_use) ||
                ((state == ST_MD_BUSY) && !hz.md_done));
  end

  assign hz.pc_stall     = hold;
  assign hz.if_id_stall  = hold;
  assign hz.if_id_flush  = flush;
  assign hz.decode_stall = hold || flush;
  assign hz.md_timeout   = md_timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      cnt          <= '0;
      md_timeout_q <= 1'b0;
    end else if (hz.ex_redirect) begin
      // Redirect abandons any mul/div op and (re)starts the flush window.
      cnt   <= FLUSH_RELOAD;
      state <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state)
        ST_RUN: if (hz.ex_md_start) begin
          state <= ST_MD_BUSY;
          cnt   <= '0;
        end
        ST_MD_BUSY: begin
          if (hz.md_done) begin
            state <= ST_RUN;
          end else if (cnt == MD_LAST) begin
            md_timeout_q <= 1'b1;
            state        <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt <= CNT_W'(1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  sat_counter #(.STAT_W(STAT_W)) u_stall_cnt (
    .clk(clk), .clr(rst), .inc(hold), .q(hz.stat_stall_cycles)
  );
  sat_counter #(.STAT_W(STAT_W)) u_flush_cnt (
    .clk(clk), .clr(rst), .inc(hz.ex_redirect), .q(hz.stat_flush_events)
  );
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: two DUTs (FLUSH_CYCLES=1 and 3) share stimulus; a per-cycle model plus literal checks.
module tb_pipeline_hazard_ctrl;
  localparam int MD_TO = 64;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz1 ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz3 ();

  assign hz3.id_rs1      = hz1.id_rs1;
  assign hz3.id_rs2      = hz1.id_rs2;
  assign hz3.ex_rd       = hz1.ex_rd;
  assign hz3.id_use_rs1  = hz1.id_use_rs1;
  assign hz3.id_use_rs2  = hz1.id_use_rs2;
  assign hz3.ex_mem_read = hz1.ex_mem_read;
  assign hz3.ex_redirect = hz1.ex_redirect;
  assign hz3.ex_md_start = hz1.ex_md_start;
  assign hz3.md_done     = hz1.md_done;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .MD_TIMEOUT(MD_TO)) u_dut1 (
    .clk(clk), .rst(rst), .hz(hz1.slave));
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .MD_TIMEOUT(MD_TO)) u_dut3 (
    .clk(clk), .rst(rst), .hz(hz3.slave));

  // {pc_stall, if_id_stall, if_id_flush, decode_stall, md_timeout}
  function automatic logic [4:0] outs(input int d);
    if (d == 0) return {hz1.pc_stall, hz1.if_id_stall, hz1.if_id_flush, hz1.decode_stall, hz1.md_timeout};
    return {hz3.pc_stall, hz3.if_id_stall, hz3.if_id_flush, hz3.decode_stall, hz3.md_timeout};
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 waiting on mul/div, 2 flushing
  int fcs [2] = '{1, 3};
  int m_mode [2] = '{0, 0}, n_mode [2] = '{0, 0};
  int m_left [2] = '{0, 0}, n_left [2] = '{0, 0};
  int m_el   [2] = '{0, 0}, n_el   [2] = '{0, 0};
  int m_to   [2] = '{0, 0}, n_to   [2] = '{0, 0};
  int m_sc   [2] = '{0, 0}, n_sc   [2] = '{0, 0};
  int m_fe   [2] = '{0, 0}, n_fe   [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit haz, e_hold, e_flush;
      logic [4:0] exp_o;
      haz = hz1.ex_mem_read && (hz1.ex_rd != 0) &&
            ((hz1.id_use_rs1 && hz1.id_rs1 == hz1.ex_rd) ||
             (hz1.id_use_rs2 && hz1.id_rs2 == hz1.ex_rd));
      e_hold = 0; e_flush = 0;
      n_mode[d] = m_mode[d]; n_left[d] = m_left[d]; n_el[d] = m_el[d]; n_to[d] = m_to[d];
      if (rst) begin
        n_mode[d] = 0; n_left[d] = 0; n_el[d] = 0; n_to[d] = 0;
      end else if (hz1.ex_redirect) begin
        e_flush = 1;
        n_left[d] = fcs[d] - 1;
        n_mode[d] = (n_left[d] > 0) ? 2 : 0;
      end else if (m_mode[d] == 0) begin
        if (hz1.ex_md_start) begin n_mode[d] = 1; n_el[d] = 0; end
        else e_hold = haz;
      end else if (m_mode[d] == 1) begin
        if (hz1.md_done) n_mode[d] = 0;
        else begin
          e_hold = 1;
          if (m_el[d] == MD_TO - 1) begin n_to[d] = 1; n_mode[d] = 0; end
          else n_el[d] = m_el[d] + 1;
        end
      end else begin
        e_flush = 1;
        n_left[d] = m_left[d] - 1;
        if (n_left[d] == 0) n_mode[d] = 0;
      end
      n_sc[d] = rst ? 0 : m_sc[d] + int'(e_hold);
      n_fe[d] = rst ? 0 : m_fe[d] + int'(hz1.ex_redirect);
      exp_o = {e_hold, e_hold, e_flush, e_hold | e_flush, m_to[d] != 0};
      if (!rst) begin
        checks++;
        if (outs(d) !== exp_o) begin
          errors++;
          $display("FAIL model_outs dut%0d t=%0t got=%b expected=%b", d, $time, outs(d), exp_o);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if ((d == 0 ? hz1.stat_stall_cycles : hz3.stat_stall_cycles) !== 32'(m_sc[d]) ||
            (d == 0 ? hz1.stat_flush_events : hz3.stat_flush_events) !== 32'(m_fe[d])) begin
          errors++;
          $display("FAIL model_stats dut%0d t=%0t got=%0d/%0d expected=%0d/%0d", d, $time,
                   (d == 0 ? hz1.stat_stall_cycles : hz3.stat_stall_cycles),
                   (d == 0 ? hz1.stat_flush_events : hz3.stat_flush_events), m_sc[d], m_fe[d]);
        end
`endif
      end
    end
  end

  always @(posedge clk) begin
    m_mode = n_mode; m_left = n_left; m_el = n_el; m_to = n_to; m_sc = n_sc; m_fe = n_fe;
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic clr_in();
    hz1.id_rs1 = 0; hz1.id_rs2 = 0; hz1.ex_rd = 0;
    hz1.id_use_rs1 = 0; hz1.id_use_rs2 = 0; hz1.ex_mem_read = 0;
    hz1.ex_redirect = 0; hz1.ex_md_start = 0; hz1.md_done = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    smp();
    chk("reset_outs_dut1", 32'(outs(0)), 32'b0);
    chk("reset_outs_dut3", 32'(outs(1)), 32'b0);

    // 1 load-use on rs2
    nxt(); hz1.ex_mem_read = 1; hz1.ex_rd = 5; hz1.id_rs2 = 5; hz1.id_use_rs2 = 1;
    smp();
    chk("loaduse_stall", 32'(outs(0)), 32'b11010);
    nxt(); clr_in(); smp();
    chk("loaduse_clear", 32'(outs(0)), 32'b0);
`ifdef HAZARD_STATS_EN
    chk("stat_stall_after_s1", hz1.stat_stall_cycles, 32'd1);
`endif

    // 2 x0 and unused operands, then an rs1 hit
    nxt(); hz1.ex_mem_read = 1; hz1.ex_rd = 0; hz1.id_rs1 = 0; hz1.id_use_rs1 = 1;
    smp(); chk("x0_no_stall", 32'(hz1.pc_stall), 32'd0);
    nxt(); hz1.ex_rd = 7; hz1.id_rs1 = 7; hz1.id_use_rs1 = 0; hz1.id_rs2 = 3; hz1.id_use_rs2 = 1;
    smp(); chk("unused_no_stall", 32'(hz1.pc_stall), 32'd0);
    nxt(); hz1.id_use_rs1 = 1;
    smp(); chk("rs1_stall", 32'(hz1.if_id_stall), 32'd1);
    nxt(); clr_in();

    // 3 redirect: one flush cycle vs three
    nxt(); hz1.ex_redirect = 1;
    smp();
    chk("redir_dut1", 32'(outs(0)), 32'b00110);
    chk("redir_dut3", 32'(outs(1)), 32'b00110);
    cnt = 1;
    nxt(); clr_in(); smp();
    chk("redir_dut1_done", 32'(hz1.if_id_flush), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (hz3.if_id_flush) cnt++;
      nxt(); smp();
    end
    chk("flush3_len", 32'(cnt), 32'd3);
`ifdef HAZARD_STATS_EN
    chk("stat_flush_after_s3", hz1.stat_flush_events, 32'd1);
`endif

    // 4a mul/div, done after 10 stall cycles
    nxt(); hz1.ex_md_start = 1;
    smp(); chk("md_start_no_stall", 32'(hz1.pc_stall), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      nxt(); clr_in(); smp();
      if (hz1.pc_stall) cnt++;
    end
    chk("md_stall_len", 32'(cnt), 32'd10);
    nxt(); hz1.md_done = 1;
    smp(); chk("md_done_drop", 32'(outs(0)), 32'b0);
    nxt(); clr_in();

    // 4b watchdog
    nxt(); hz1.ex_md_start = 1;
    nxt(); clr_in(); smp();
    cnt = 0;
    for (int i = 0; i < 100 && hz1.pc_stall; i++) begin
      cnt++;
      nxt(); smp();
    end
    chk("md_timeout_len", 32'(cnt), 32'd64);
    chk("md_timeout_set", 32'(outs(0)), 32'b00001);
    repeat (3) nxt();
    smp(); chk("md_timeout_sticky", 32'(hz3.md_timeout), 32'd1);

    // 5a redirect + md_start + load-use together
    nxt(); hz1.ex_redirect = 1; hz1.ex_md_start = 1;
    hz1.ex_mem_read = 1; hz1.ex_rd = 9; hz1.id_rs1 = 9; hz1.id_use_rs1 = 1;
    smp(); chk("collide_flush_only", 32'(outs(0)), 32'b00111);
    nxt(); clr_in(); smp();
    chk("collide_no_mdbusy", 32'(outs(0)), 32'b00001);
    repeat (3) nxt();

    // 5b redirect during MD_BUSY, then stale md_done
    nxt(); hz1.ex_md_start = 1;
    nxt(); clr_in();
    repeat (3) nxt();
    hz1.ex_redirect = 1;
    smp(); chk("md_redirect", 32'(outs(0)), 32'b00111);
    nxt(); clr_in(); smp();
    chk("md_abandoned", 32'(hz1.pc_stall), 32'd0);
    nxt(); hz1.md_done = 1;
    smp(); chk("stale_md_done", 32'(hz3.pc_stall), 32'd0);
    nxt(); clr_in();
    repeat (3) nxt();

    // 5c redirect restarts flush window
    hz1.ex_redirect = 1;
    cnt = 0;
    smp(); if (hz3.if_id_flush) cnt++;
    nxt(); smp(); if (hz3.if_id_flush) cnt++;
    nxt(); clr_in();
    for (int i = 0; i < 6; i++) begin
      smp(); if (hz3.if_id_flush) cnt++;
      nxt();
    end
    chk("flush_restart_len", 32'(cnt), 32'd4);

    // 6 reset mid-MD_BUSY clears sticky timeout too
    hz1.ex_md_start = 1;
    nxt(); clr_in();
    repeat (4) nxt();
    rst = 1'b1;
    nxt(); rst = 1'b0;
    smp();
    chk("rst_mid_md_dut1", 32'(outs(0)), 32'b0);
    chk("rst_mid_md_dut3", 32'(outs(1)), 32'b0);
`ifdef HAZARD_STATS_EN
    chk("stat_stall_rst", hz1.stat_stall_cycles, 32'd0);
    chk("stat_flush_rst", hz1.stat_flush_events, 32'd0);
`endif
    repeat (2) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
